// File: rtl/qam16_pkg.sv
// Shared QAM16 transmit definitions: sample width, sequencer states and a
// counter-width helper.
package qam16_pkg;

    localparam int unsigned QAM16_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } tx_state_e;

    // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qam_tx_sequencer_valid_delay.sv
// Fixed-depth delay line for a single valid bit, cleared by reset.
module valid_delay #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift the new bit in at the bottom; the oldest bit leaves at the top.
    always_comb begin
        sr_d = (sr_q << 1) | DEPTH'(din);
    end

    // Delay-line register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/qam_tx_sequencer.sv
// QAM16 transmit sequencer: upsamples symbols by zero-stuffing to SPS samples
// per symbol, inserts zero symbols on upstream underrun, flushes the RRC
// filter with TAPS-1 zeros after the last symbol, and tracks filter latency.
module qam_tx_sequencer
    import qam16_pkg::*;
#(
    parameter int unsigned SPS      = 4,
    parameter int unsigned TAPS     = 11,
    parameter int unsigned FILT_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sym_valid,
    input  logic signed [QAM16_W-1:0] sym_data,
    input  logic                      sym_last,
    output logic                      sym_ready,
    output logic signed [QAM16_W-1:0] filt_din,
    output logic                      filt_en,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      underrun,
    output logic [15:0]               underrun_cnt
);

    localparam int unsigned PH_W = cnt_width(SPS);
    localparam int unsigned FL_W = cnt_width(TAPS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPS - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(TAPS - 2);

    tx_state_e                 state_q, state_d;
    logic [PH_W-1:0]           phase_q, phase_d;
    logic [FL_W-1:0]           flush_q, flush_d;
    logic signed [QAM16_W-1:0] sym_q, sym_d;
    logic                      last_q, last_d;
    logic                      underrun_q, underrun_d;
    logic [15:0]               underrun_cnt_q, underrun_cnt_d;
    logic                      ready_en_q, ready_en_d;
    logic                      at_slot_end;
    logic                      accept;

    // Next-state, symbol capture, underrun insertion and handshake.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        flush_d        = flush_q;
        sym_d          = sym_q;
        last_d         = last_q;
        underrun_d     = 1'b0;
        underrun_cnt_d = underrun_cnt_q;
        ready_en_d     = 1'b1;

        at_slot_end = (state_q == ST_RUN) && (phase_q == PH_LAST);
        // ready_en_q holds sym_ready low through reset and until the first edge after it.
        sym_ready   = ready_en_q && ((state_q == ST_IDLE) || (at_slot_end && !last_q));
        accept      = sym_valid && sym_ready;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                    sym_d   = sym_data;
                    last_d  = sym_last;
                end
            end
            ST_RUN: begin
                if (phase_q != PH_LAST) begin
                    phase_d = phase_q + PH_W'(1);
                end else begin
                    phase_d = '0;
                    if (last_q) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end else if (accept) begin
                        sym_d  = sym_data;
                        last_d = sym_last;
                    end else begin
                        // Starved: send a zero symbol slot and keep the burst open.
                        sym_d          = '0;
                        last_d         = 1'b0;
                        underrun_d     = 1'b1;
                        underrun_cnt_d = (underrun_cnt_q == 16'hFFFF) ? underrun_cnt_q
                                                                      : underrun_cnt_q + 16'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == FL_LAST) begin
                    state_d = ST_IDLE;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + FL_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            flush_q        <= '0;
            sym_q          <= '0;
            last_q         <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
            ready_en_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            flush_q        <= flush_d;
            sym_q          <= sym_d;
            last_q         <= last_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
            ready_en_q     <= ready_en_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign filt_en      = busy;
    assign filt_din     = ((state_q == ST_RUN) && (phase_q == '0)) ? sym_q : '0;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

    valid_delay #(
        .DEPTH (FILT_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (filt_en),
        .dout  (out_valid)
    );

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Self-checking bench for qam_tx_sequencer: bursts are described as symbol
// slot lists and the expected sample stream is derived from those lists.
module tb_qam_tx_sequencer;

    localparam int unsigned SPS      = 4;
    localparam int unsigned TAPS     = 11;
    localparam int unsigned FILT_LAT = 3;
    localparam int          GAP      = 100;   // slot marker: upstream withholds a symbol

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sym_valid = 1'b0;
    logic [3:0]  sym_data = '0;
    logic        sym_last = 1'b0;
    logic        sym_ready;
    logic [3:0]  filt_din;
    logic        filt_en;
    logic        out_valid;
    logic        busy;
    logic        underrun;
    logic [15:0] underrun_cnt;

    qam_tx_sequencer #(
        .SPS      (SPS),
        .TAPS     (TAPS),
        .FILT_LAT (FILT_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sym_valid    (sym_valid),
        .sym_data     (sym_data),
        .sym_last     (sym_last),
        .sym_ready    (sym_ready),
        .filt_din     (filt_din),
        .filt_en      (filt_en),
        .out_valid    (out_valid),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [15:0] m_cnt = '0;
    bit          en_hist[$];
    int          slots[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare every output for one cycle against the expected burst view.
    task automatic check_cycle(input bit en, input logic [3:0] din, input bit rdy, input bit und);
        bit ov;
        en_hist.push_back(en);
        ov = (en_hist.size() > FILT_LAT) ? en_hist[en_hist.size() - 1 - FILT_LAT] : 1'b0;
        if (und) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        check_eq("busy", busy, en);
        check_eq("filt_en", filt_en, en);
        check_eq("filt_din", filt_din, din);
        check_eq("sym_ready", sym_ready, rdy);
        check_eq("underrun", underrun, und);
        check_eq("underrun_cnt", underrun_cnt, m_cnt);
        check_eq("out_valid", out_valid, ov);
        if (en_hist.size() > 16) void'(en_hist.pop_front());
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_filt_en"}, filt_en, 1'b0);
        check_eq({tag, "_filt_din"}, filt_din, 4'h0);
        check_eq({tag, "_out_valid"}, out_valid, 1'b0);
        check_eq({tag, "_underrun"}, underrun, 1'b0);
        check_eq({tag, "_underrun_cnt"}, underrun_cnt, 16'h0);
        check_eq({tag, "_sym_ready"}, sym_ready, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            check_cycle(1'b0, 4'h0, 1'b1, 1'b0);
            sym_valid = 1'b0;
            sym_data  = 4'($urandom);
            sym_last  = 1'($urandom);
            @(negedge clk);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE
    // cycle after the flush. abort_k >= 0 asserts reset after that burst cycle.
    task automatic run_burst(input int sl[$], input int abort_k);
        int         ns;
        int         total;
        int         s;
        int         p;
        bit         in_run;
        bit         gap;
        bit         rdy;
        logic [3:0] d;
        ns    = sl.size();
        total = ns * SPS + TAPS - 1;
        check_cycle(1'b0, 4'h0, 1'b1, 1'b0);
        sym_valid = 1'b1;
        sym_data  = 4'(sl[0]);
        sym_last  = (ns == 1);
        @(negedge clk);
        for (int k = 0; k < total; k++) begin
            s      = k / SPS;
            p      = k % SPS;
            in_run = (s < ns);
            gap    = in_run && (sl[s] == GAP);
            d      = (in_run && p == 0 && !gap) ? 4'(sl[s]) : 4'h0;
            rdy    = in_run && (p == SPS - 1) && (s != ns - 1);
            check_cycle(1'b1, d, rdy, in_run && p == 0 && gap);
            if (k == abort_k) begin
                rst_n     = 1'b0;
                sym_valid = 1'b0;
                #1;
                check_reset_state("abort");
                m_cnt = '0;
                en_hist.delete();
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            if (rdy && sl[s + 1] != GAP) begin
                sym_valid = 1'b1;
                sym_data  = 4'(sl[s + 1]);
                sym_last  = (s + 1 == ns - 1);
            end else if (rdy) begin
                sym_valid = 1'b0;
                sym_data  = 4'($urandom);
                sym_last  = 1'($urandom);
            end else begin
                sym_valid = 1'($urandom);
                sym_data  = 4'($urandom);
                sym_last  = 1'($urandom);
            end
            @(negedge clk);
        end
        sym_valid = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en_hist.delete();
        @(negedge clk);
        idle(3);

        slots = {7};
        run_burst(slots, -1);
        idle(2);
        slots = {3, -2, 5};
        run_burst(slots, -1);
        idle(1);
        slots = {3, GAP, 1};
        run_burst(slots, -1);
        check_eq("und_cnt_one", underrun_cnt, 16'd1);
        idle(1);

        // Back-to-back single-symbol bursts: exactly one IDLE cycle between.
        slots = {2};
        run_burst(slots, -1);
        slots = {-5};
        run_burst(slots, -1);
        idle(1);

        slots = {1, -3, 6};
        run_burst(slots, int'(SPS) + 2);
        idle(TAPS + 2);

        for (int b = 0; b < 20; b++) begin
            slots.delete();
            n = int'($urandom_range(5, 1));
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(99) < 30) slots.push_back(GAP);
                slots.push_back(int'($urandom_range(15)) - 8);
            end
            run_burst(slots, -1);
            if ($urandom_range(1) == 1) idle(int'($urandom_range(3, 1)));
        end

        idle(1);
        check_cycle(1'b0, 4'h0, 1'b1, 1'b0);
        force dut.underrun_cnt_d = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.underrun_cnt_d;
        m_cnt = 16'hFFFE;
        @(negedge clk);
        slots = {1, GAP, 2, GAP, 3, GAP, 4};
        run_burst(slots, -1);
        check_eq("und_cnt_sat", underrun_cnt, 16'hFFFF);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/qam_tx_sequencer.md
QAM_TX_SEQUENCER -- requirements
Module: qam_tx_sequencer

Interface
REQ-001 SHALL have parameter SPS, default 4: samples per symbol (upsampling factor), legal range 2..16.
REQ-002 SHALL have parameter TAPS, default 11: RRC filter tap count, which sets the flush length.
REQ-003 SHALL have parameter FILT_LAT, default 1: RRC filter input-to-output latency in cycles, legal range 1..8.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 sym_valid  in  1  upstream symbol valid.
REQ-007 sym_data  in  4  signed QAM16 I or Q level.
REQ-008 sym_last  in  1  marks the final symbol of a burst; qualified by sym_valid.
REQ-009 sym_ready  out  1  symbol accepted when sym_valid and sym_ready are both high.
REQ-010 filt_din  out  4  signed sample to the RRC filter din.
REQ-011 filt_en  out  1  filt_din carries a burst sample (data, zero-stuff or flush).
REQ-012 out_valid  out  1  filter dout is meaningful this cycle.
REQ-013 busy  out  1  state is not IDLE.
REQ-014 underrun  out  1  one-cycle pulse when a zero symbol is inserted.
REQ-015 underrun_cnt  out  16  saturating count of inserted zero symbols.

Function
REQ-016 FSM states SHALL be IDLE, RUN and FLUSH.
REQ-017 IDLE: sym_ready=1, filt_en=0, filt_din=0.
REQ-018 Accept in IDLE: next cycle state=RUN, phase=0, filt_din=sym_data, filt_en=1.
REQ-019 RUN: phase counter SHALL count 0..SPS-1 and wrap; filt_din=symbol at phase 0, 0 at phases 1..SPS-1; filt_en=1.
REQ-020 RUN: sym_ready SHALL be 1 only at phase SPS-1, and only if the current symbol was not the last.
REQ-021 Accept at phase SPS-1: next symbol SHALL drive filt_din at the following phase 0, giving no gap between symbols.
REQ-022 RUN, phase SPS-1, no sym_valid, current symbol not last: next phase 0 SHALL output 0, pulse underrun for one cycle, increment underrun_cnt (saturating at 0xFFFF), and stay in RUN.
REQ-023 Last symbol: after its phase SPS-1, state SHALL go to FLUSH with flush counter 0.
REQ-024 FLUSH: filt_din=0, filt_en=1, sym_ready=0 for exactly TAPS-1 cycles, then IDLE.
REQ-025 Accept in the final FLUSH cycle SHALL NOT occur (sym_ready=0); IDLE is always visited for at least one cycle between bursts.
REQ-026 out_valid SHALL equal filt_en delayed by exactly FILT_LAT cycles via a shift register.
REQ-027 sym_data SHALL be captured on accept only and held internally; later changes on sym_data SHALL be ignored.
REQ-028 A burst of N symbols SHALL produce exactly N*SPS + TAPS-1 cycles of filt_en=1.
REQ-029 Phase counter width SHALL be clog2(SPS); flush counter width SHALL be clog2(TAPS).

Reset
REQ-030 rst_n low SHALL force state=IDLE, all counters=0, filt_din=0, filt_en=0, out_valid=0 (delay line cleared), underrun=0, underrun_cnt=0, sym_ready=0 while asserted.
REQ-031 Reset asserted mid-burst SHALL abort the burst immediately; no flush SHALL be emitted.
REQ-032 After rst_n deasserts, sym_ready SHALL rise on the first clock edge.

Structure
REQ-033 State encoding enum and the QAM16 sample width constant (4) SHALL live in shared package qam16_pkg.
REQ-034 The FILT_LAT valid delay line SHALL be sub-module valid_delay, parameterised by depth.
REQ-035 The RRC filter SHALL NOT be instantiated inside this block; integration happens at the qam16 top level.

Verification
REQ-036 SPS=4, TAPS=11, single symbol +7 with last -> filt_din 7,0,0,0 then ten 0s; filt_en high for 14 cycles; out_valid high for 14 cycles starting FILT_LAT later.
REQ-037 Back-to-back symbols 3,-2,5 (last) with sym_valid held high -> filt_din 3,0,0,0,-2,0,0,0,5,0,0,0 then 10 zeros; no underrun.
REQ-038 sym_valid dropped for one symbol slot mid-burst -> four zero samples, underrun pulses once, underrun_cnt=1.
REQ-039 rst_n asserted at phase 2 of the second symbol -> next cycle busy=0, filt_en=0, out_valid=0, underrun_cnt=0.
REQ-040 Two consecutive bursts of one symbol each -> at least one IDLE cycle between them; the second burst's first sample is correct.
REQ-041 Force underrun_cnt to 0xFFFE, then cause 3 underruns -> underrun_cnt holds at 0xFFFF.
